// File: rtl/fnd_pkg.sv
// Shared FND definitions: segment codes, scan-decoder FSM states and widths.
// Segment codes are active-low {g,f,e,d,c,b,a}; the dp bit is handled separately.
package fnd_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned VALUE_W    = 14;

    localparam logic [3:0] COM_BLANK   = 4'hF;
    localparam logic [3:0] BCD_INVALID = 4'hF;

    localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        ST_WAIT_STABLE,
        ST_ACCEPT,
        ST_WAIT_CHANGE
    } fnd_state_t;

    // Encoder used by the FND display drivers; inverse of fnd_seg_decode.
    function automatic logic [SEG_W-1:0] seg_encode(input logic [DIGIT_W-1:0] digit);
        logic [SEG_W-1:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/fnd_seg_decode.sv
// Combinational 7-segment pattern to BCD decoder; unknown patterns give 4'hF with valid low.
module fnd_seg_decode
    import fnd_pkg::*;
(
    input  logic [SEG_W-1:0]   seg,
    output logic [DIGIT_W-1:0] digit,
    output logic               valid
);

    always_comb begin
        digit = BCD_INVALID;
        valid = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: begin
                digit = BCD_INVALID;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Recovers the four digits shown on a multiplexed FND by sniffing its scan lines,
// debouncing each digit/segment pair and publishing complete frames as BCD and binary.
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [3:0]                     fnd_com,
    input  logic [7:0]                     fnd_data,
    output logic [NUM_DIGITS*DIGIT_W-1:0]  bcd,
    output logic [NUM_DIGITS-1:0]          dp,
    output logic [VALUE_W-1:0]             value,
    output logic                           frame_valid,
    output logic                           frame_err,
    output logic                           com_err
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [11:0] PAIR_IDLE = {COM_BLANK, 8'hFF};

    logic [11:0]                      in_q;
    logic [11:0]                      samp_q;
    logic [11:0]                      acc_q;
    logic [SETTLE_W-1:0]              settle_cnt;
    fnd_state_t                       state;

    logic [NUM_DIGITS*DIGIT_W-1:0]    sh_bcd;
    logic [NUM_DIGITS-1:0]            sh_dp;
    logic [NUM_DIGITS-1:0]            mask;
    logic [NUM_DIGITS-1:0]            inval;
    logic                             complete_q;
    logic [TMO_W-1:0]                 idle_cnt;

    logic [3:0]                       samp_com;
    logic                             stable;
    logic                             com_onehot;
    logic [1:0]                       slot;
    logic [NUM_DIGITS-1:0]            mask_set;
    logic                             accept_now;
    logic                             store_now;
    logic [DIGIT_W-1:0]               dec_digit;
    logic                             dec_valid;
    logic [VALUE_W-1:0]               value_c;

    fnd_seg_decode u_seg_decode (
        .seg   (samp_q[SEG_W-1:0]),
        .digit (dec_digit),
        .valid (dec_valid)
    );

    assign samp_com   = samp_q[11:8];
    assign stable     = (settle_cnt == SETTLE_W'(SETTLE_CYCLES));
    assign com_onehot = $onehot(~samp_com);
    assign accept_now = (state == ST_WAIT_STABLE) && stable && (samp_com != COM_BLANK);
    assign store_now  = accept_now && com_onehot;
    assign mask_set   = mask | (NUM_DIGITS'(1) << slot);

    always_comb begin
        slot = '0;
        case (samp_com)
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: slot = '0;
        endcase
    end

    always_comb begin
        value_c = VALUE_W'(sh_bcd[15:12]) * VALUE_W'(1000)
                + VALUE_W'(sh_bcd[11:8])  * VALUE_W'(100)
                + VALUE_W'(sh_bcd[7:4])   * VALUE_W'(10)
                + VALUE_W'(sh_bcd[3:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Sampler starts at the blanked pair so a held reset value never looks like a stable illegal com.
            in_q        <= PAIR_IDLE;
            samp_q      <= PAIR_IDLE;
            acc_q       <= PAIR_IDLE;
            settle_cnt  <= '0;
            state       <= ST_WAIT_STABLE;
            sh_bcd      <= '0;
            sh_dp       <= '0;
            mask        <= '0;
            inval       <= '0;
            complete_q  <= 1'b0;
            idle_cnt    <= '0;
            bcd         <= '0;
            dp          <= '0;
            value       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            com_err     <= 1'b0;
        end else begin
            in_q   <= {fnd_com, fnd_data};
            samp_q <= in_q;
            if (in_q == samp_q) begin
                if (!stable) begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
            end else begin
                settle_cnt <= SETTLE_W'(1);
            end

            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            com_err     <= 1'b0;
            complete_q  <= 1'b0;

            case (state)
                ST_WAIT_STABLE: begin
                    if (accept_now) begin
                        state   <= ST_ACCEPT;
                        acc_q   <= samp_q;
                        com_err <= ~com_onehot;
                    end
                end
                ST_ACCEPT: begin
                    state <= ST_WAIT_CHANGE;
                end
                ST_WAIT_CHANGE: begin
                    if (samp_q != acc_q) begin
                        state <= ST_WAIT_STABLE;
                    end
                end
                default: begin
                    state <= ST_WAIT_STABLE;
                end
            endcase

            // Completion is handled one cycle after the last store, so it can never share a cycle with a store or com_err.
            if (complete_q) begin
                if (inval == '0) begin
                    bcd         <= sh_bcd;
                    dp          <= sh_dp;
                    value       <= value_c;
                    frame_valid <= 1'b1;
                end else begin
                    frame_err   <= 1'b1;
                end
                mask     <= '0;
                inval    <= '0;
                idle_cnt <= '0;
            end else if (store_now) begin
                sh_bcd[slot*DIGIT_W +: DIGIT_W] <= dec_digit;
                sh_dp[slot]                     <= ~samp_q[7];
                inval[slot]                     <= ~dec_valid;
                mask                            <= mask_set;
                complete_q                      <= (mask_set == '1);
                idle_cnt                        <= '0;
            end else if (mask != '0) begin
                if (idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    mask     <= '0;
                    inval    <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule
